// File: rtl/uart_tx_fifo_core.sv
// rtl/uart_tx_fifo_core.sv - parametrised UART transmitter with internal transmit FIFO
module uart_tx_fifo_core #(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx_data_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_ack,
  output logic                          tx_pin
);

  localparam int CYCLE = CLK_FRE * 1000000 / BAUD_RATE;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;

  localparam logic [15:0]   CYC_LAST  = 16'(CYCLE - 1);
  localparam logic [15:0]   CYC_ACK   = 16'(CYCLE - 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

  if (CYCLE < 2 || CYCLE > 65535) begin : g_bad_cycle
    $error("uart_tx_fifo_core: bit time must be 2..65535 clocks");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo_core: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo_core: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo_core: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("uart_tx_fifo_core: FIFO_DEPTH must be a power of two in 2..256");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level_next;
  logic [DATA_BITS-1:0] head;
  logic                 push, pop, avail;

  state_t               state, state_n;
  logic [15:0]          cnt, cnt_n;
  logic [3:0]           idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bit, par_n;
  logic                 pin_n, busy_n, ack_n;

  assign push       = tx_data_valid && tx_data_ready;
  assign level_next = fifo_level + LW'(push) - LW'(pop);
  assign head       = mem[rd_ptr];

  // FIFO storage written on accept; left unreset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers, occupancy, registered ready and the delayed non-empty flag
  // that gives the fixed two-clock accept-to-start-bit latency from idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_level    <= '0;
      tx_data_ready <= 1'b0;
      avail         <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level    <= level_next;
      tx_data_ready <= (level_next != DEPTH_L);
      avail         <= (fifo_level != '0);
    end
  end

  // Engine state register and registered line outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx_pin  <= 1'b1;
      tx_busy <= 1'b0;
      tx_ack  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      par_bit <= par_n;
      tx_pin  <= pin_n;
      tx_busy <= busy_n;
      tx_ack  <= ack_n;
    end
  end

  // Next-state: frame sequencing, bit timing, FIFO pop at frame launch
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    par_n   = par_bit;
    pin_n   = tx_pin;
    busy_n  = tx_busy;
    ack_n   = 1'b0;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (avail && fifo_level != '0) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = (PARITY == 1) ? ~(^head) : ^head;
          pin_n   = 1'b0;
          busy_n  = 1'b1;
          cnt_n   = '0;
          idx_n   = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        if (cnt == CYC_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          pin_n   = shift[0];
          state_n = S_DATA;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == CYC_LAST) begin
          cnt_n = '0;
          if (idx == DATA_LAST) begin
            idx_n = '0;
            if (PARITY != 0) begin
              pin_n   = par_bit;
              state_n = S_PARITY;
            end else begin
              pin_n   = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            idx_n   = idx + 4'd1;
            shift_n = shift >> 1;
            pin_n   = shift[1];
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_PARITY: begin
        if (cnt == CYC_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          pin_n   = 1'b1;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_STOP: begin
        // ack is raised so that it is visible during the final stop clock
        if (idx == STOP_LAST && cnt == CYC_ACK) ack_n = 1'b1;
        if (cnt == CYC_LAST) begin
          cnt_n = '0;
          if (idx == STOP_LAST) begin
            idx_n = '0;
            if (fifo_level != '0) begin
              pop     = 1'b1;
              shift_n = head;
              par_n   = (PARITY == 1) ? ~(^head) : ^head;
              pin_n   = 1'b0;
              state_n = S_START;
            end else begin
              busy_n  = 1'b0;
              state_n = S_IDLE;
            end
          end else begin
            idx_n = idx + 4'd1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        pin_n   = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// tb/tb_uart_tx_fifo_core.sv - self-checking bench for uart_tx_fifo_core
module tb_uart_tx_fifo_core;

  localparam int CYC = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] valid, ready, busy, ack, pin;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [4:0] lvl0;
  logic [2:0] lvl1, lvl2, lvl3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ack_cnt0 = 0;
  int falls[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ack[0]) ack_cnt0 <= ack_cnt0 + 1;

  uart_tx_fifo_core #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                      .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .tx_data(d0), .tx_data_valid(valid[0]),
    .tx_data_ready(ready[0]), .tx_busy(busy[0]), .fifo_level(lvl0),
    .tx_ack(ack[0]), .tx_pin(pin[0]));

  uart_tx_fifo_core #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2),
                      .STOP_BITS(1), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .tx_data(d1), .tx_data_valid(valid[1]),
    .tx_data_ready(ready[1]), .tx_busy(busy[1]), .fifo_level(lvl1),
    .tx_ack(ack[1]), .tx_pin(pin[1]));

  uart_tx_fifo_core #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1),
                      .STOP_BITS(1), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .tx_data(d2), .tx_data_valid(valid[2]),
    .tx_data_ready(ready[2]), .tx_busy(busy[2]), .fifo_level(lvl2),
    .tx_ack(ack[2]), .tx_pin(pin[2]));

  uart_tx_fifo_core #(.CLK_FRE(1), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(0),
                      .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
    .clk(clk), .rst_n(rst_n), .tx_data(d3), .tx_data_valid(valid[3]),
    .tx_data_ready(ready[3]), .tx_busy(busy[3]), .fifo_level(lvl3),
    .tx_ack(ack[3]), .tx_pin(pin[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int nb(input int k);
    return (k == 3) ? 7 : 8;
  endfunction

  function automatic int pm(input int k);
    return (k == 1) ? 2 : (k == 2) ? 1 : 0;
  endfunction

  function automatic int ns(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int frame_bits(input int k);
    return 1 + nb(k) + ((pm(k) != 0) ? 1 : 0) + ns(k);
  endfunction

  // expected line level for bit slot b of the frame carrying word w
  function automatic logic exp_bit(input int k, input int w, input int b);
    logic [31:0] m;
    int n;
    n = nb(k);
    m = w & ((1 << n) - 1);
    if (b == 0) return 1'b0;
    if (b <= n) return m[b-1];
    if (pm(k) != 0 && b == n + 1) return (pm(k) == 2) ? ^m : ~^m;
    return 1'b1;
  endfunction

  task automatic set_data(input int k, input int w);
    case (k)
      0: d0 = 8'(w);
      1: d1 = 8'(w);
      2: d2 = 8'(w);
      default: d3 = 7'(w);
    endcase
  endtask

  task automatic send(input int k, input int w, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    set_data(k, w);
    valid[k] = 1'b1;
    while (!ready[k] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    acc = cyc;
    valid[k] = 1'b0;
  endtask

  task automatic check_frame(input int k, input int w, input int exp_fall, input string tag);
    int t, len, bad, nack, ack_at, busy_low;
    t = 0;
    len = frame_bits(k) * CYC;
    @(negedge clk);
    while (pin[k] && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) begin
      chk({tag, "_start_timeout"}, 0, 1);
      return;
    end
    falls.push_back(cyc);
    if (exp_fall >= 0) chk({tag, "_start_cycle"}, cyc, exp_fall);
    bad = 0; nack = 0; ack_at = -1; busy_low = 0;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk);
      if (pin[k] !== exp_bit(k, w, i / CYC)) bad++;
      if (ack[k]) begin nack++; ack_at = i; end
      if (!busy[k]) busy_low++;
    end
    chk({tag, "_bit_errors"}, bad, 0);
    chk({tag, "_ack_count"}, nack, 1);
    chk({tag, "_ack_pos"}, ack_at, len - 1);
    chk({tag, "_busy_low"}, busy_low, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, w, a0, lows, acks_rst, f0, n0, t;
    int ws[6];
    rst_n = 1'b0;
    valid = '0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;

    repeat (3) @(negedge clk);
    chk("rst_pin", 32'(pin), 32'hF);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_level", 32'(lvl0) + 32'(lvl1) + 32'(lvl2) + 32'(lvl3), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_first_edge", 32'(ready), 32'hF);

    // single 8N1 frame, latency and completion
    fork
      send(0, 'hA5, acc);
      check_frame(0, 'hA5, -1, "a5");
    join
    chk("a5_latency", falls[$] - acc, 2);
    @(negedge clk);
    chk("a5_busy_after", 32'(busy[0]), 0);
    chk("a5_level_after", 32'(lvl0), 0);

    // even parity, odd parity, 7 data bits with 2 stop bits
    for (int k = 1; k < 4; k++) begin
      w = (k == 3) ? 'h55 : 'h07;
      fork
        send(k, w, acc);
        check_frame(k, w, -1, $sformatf("cfg%0d", k));
      join
      chk($sformatf("cfg%0d_latency", k), falls[$] - acc, 2);
    end

    // burst of 20 incrementing words with valid held high
    w = $urandom_range(0, 255);
    fork
      begin
        int i, tb;
        bit seen_full, seen_back;
        i = 0; tb = 0; seen_full = 0; seen_back = 0;
        @(negedge clk);
        d0 = 8'(w);
        valid[0] = 1'b1;
        while (i < 20 && tb < 5000) begin
          if (ready[0]) begin
            @(posedge clk);
            i++;
            @(negedge clk);
            if (i < 20) d0 = 8'(w + i);
            else valid[0] = 1'b0;
          end else begin
            if (!seen_full) begin
              seen_full = 1;
              chk("burst_accepted_before_full", i, 17);
              chk("burst_level_full", 32'(lvl0), 16);
            end
            @(negedge clk);
          end
          if (seen_full && !seen_back && ready[0]) begin
            seen_back = 1;
            chk("burst_level_ready_back", 32'(lvl0), 15);
          end
          tb++;
        end
        if (i < 20) chk("burst_timeout", i, 20);
      end
      begin
        for (int j = 0; j < 20; j++)
          check_frame(0, (w + j) & 255, (j == 0) ? -1 : falls[$] + 100, "burst");
      end
    join

    // push and pop coinciding at a frame boundary with three words queued
    for (int i = 0; i < 5; i++) ws[i] = $urandom_range(0, 255);
    n0 = falls.size();
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, ws[i], acc);
        t = 0;
        while (falls.size() == n0 && t < 3000) begin @(negedge clk); t++; end
        if (falls.size() == n0) chk("pp_no_frame", 0, 1);
        else begin
          f0 = falls[n0];
          while (cyc < f0 + 99) @(negedge clk);
          chk("pp_level_before", 32'(lvl0), 3);
          d0 = 8'(ws[4]);
          valid[0] = 1'b1;
          @(posedge clk);
          #1;
          valid[0] = 1'b0;
          @(negedge clk);
          chk("pp_level_after", 32'(lvl0), 3);
        end
      end
      begin
        for (int j = 0; j < 5; j++)
          check_frame(0, ws[j], (j == 0) ? -1 : falls[$] + 100, "pp");
      end
    join

    // reset in the middle of a data bit with five words queued
    ws[0] = 0;
    for (int i = 1; i < 6; i++) ws[i] = $urandom_range(0, 255);
    for (int i = 0; i < 6; i++) send(0, ws[i], acc);
    repeat (30) @(negedge clk);
    chk("mid_level_queued", 32'(lvl0), 5);
    chk("mid_pin_low_before_reset", 32'(pin[0]), 0);
    a0 = ack_cnt0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pin", 32'(pin[0]), 1);
    chk("mid_rst_level", 32'(lvl0), 0);
    chk("mid_rst_busy", 32'(busy[0]), 0);
    acks_rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack[0]) acks_rst++;
    end
    chk("mid_rst_ack", acks_rst, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready_back", 32'(ready[0]), 1);
    w = $urandom_range(0, 255);
    fork
      send(0, w, acc);
      check_frame(0, w, -1, "post_rst");
    join
    chk("post_rst_latency", falls[$] - acc, 2);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (!pin[0]) lows++;
    end
    chk("post_rst_idle_line", lows, 0);
    chk("post_rst_level", 32'(lvl0), 0);
    chk("post_rst_ack_total", ack_cnt0 - a0, 1);

    // randomized words and gaps on every configuration
    for (int k = 0; k < 4; k++) begin
      int rw[4];
      for (int i = 0; i < 4; i++) rw[i] = $urandom_range(0, (1 << nb(k)) - 1);
      fork
        begin
          int ra;
          for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 150)) @(negedge clk);
            send(k, rw[i], ra);
          end
        end
        begin
          for (int j = 0; j < 4; j++) check_frame(k, rw[j], -1, $sformatf("rand%0d", k));
        end
      join
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_core.md
Name: uart_tx_fifo_core

Overview:
- Parametrised successor to the team's single-byte UART transmitter.
- Adds the following, all fixed at elaboration:
  - configurable data width (5-9 bits)
  - optional parity (none/odd/even)
  - 1 or 2 stop bits
  - internal transmit FIFO, so producers can burst words with a standard valid/ready handshake.
- Frames are sent back-to-back with no idle gap while the FIFO holds data.
- Sits between on-chip producers (command/log engines) and the board TX pin.

Parameters:
- CLK_FRE, 50, clock frequency in MHz.
- BAUD_RATE, 115200, serial baud rate.
- DATA_BITS, 8, data bits per frame, legal 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, legal 1 or 2.
- FIFO_DEPTH, 16, FIFO entries, power of two, legal 2..256.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_BITS  word to send.
- tx_data_valid  input  1  producer has a word.
- tx_data_ready  output  1  FIFO can accept a word.
- tx_busy  output  1  engine is transmitting a frame.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently stored.
- tx_ack  output  1  one-cycle pulse at frame completion.
- tx_pin  output  1  serial output, idle high.

Behaviour:
- Interface: reset is rst_n, asynchronous, active-low; clock is clk. All outputs are registered.
- Reset values:
  - tx_pin = 1, tx_data_ready = 0, tx_busy = 0, fifo_level = 0, tx_ack = 0.
  - FIFO pointers cleared and state = IDLE.
  - tx_data_ready rises on the first clk edge after rst_n deasserts.
- Bit time: CYCLE = CLK_FRE*1000000/BAUD_RATE clocks, using a 16-bit counter. Elaboration fails if CYCLE < 2 or CYCLE > 65535.
- Handshake:
  - A word is accepted on a rising edge where tx_data_valid && tx_data_ready.
  - tx_data_ready = registered (next fifo_level != FIFO_DEPTH).
  - valid is not required to wait for ready; no word is lost or duplicated.
- FIFO:
  - Push on accept; pop when the engine leaves IDLE.
  - Push and pop in the same cycle leave fifo_level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop never happens when empty; push never happens when full.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if fifo_level != 0, pop the head into a shift latch, tx_pin <= 0, go to START, tx_busy <= 1.
  - START: hold 0 for CYCLE clocks, then go to DATA.
  - DATA: send DATA_BITS bits LSB first, CYCLE clocks each. After the last bit, go to PARITY if PARITY != 0, else STOP.
  - PARITY: send one bit for CYCLE clocks. Even = XOR of data bits; odd = its inverse.
  - STOP: hold 1 for STOP_BITS*CYCLE clocks.
- Frame completion (last clock of STOP):
  - tx_ack pulses high for 1 clk.
  - If the FIFO is non-empty, pop and go directly to START; the start bit begins on the next clock with zero idle gap and tx_busy stays 1.
  - Otherwise go to IDLE with tx_busy <= 0.
- Latency: with the engine idle and the FIFO empty, a word accepted at edge E0 drives tx_pin low at edge E0+2.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CYCLE clocks, exact with no jitter.
- Reset mid-frame: tx_pin returns to 1 immediately (asynchronous). FIFO contents are discarded. No tx_ack is issued for the aborted frame.
- tx_data is sampled only on an accept edge. FIFO storage is plain registers; no reset of the data array is required.

Test Plan:
- Config CLK_FRE=1, BAUD_RATE=100000 (CYCLE=10), 8N1. Send 0xA5 -> tx_pin shows 0,1,0,1,0,0,1,0,1,1, each bit 10 clk wide. tx_pin falls 2 clk after the accept edge. tx_ack pulses once, 100 clk after the falling edge minus 1.
- PARITY=2 then PARITY=1, send 0x07 -> parity bit 1 (even), 0 (odd). Frame length 110 clk.
- DATA_BITS=7, STOP_BITS=2, send 0x55 -> frame of start + 7 data + 2 stop = 100 clk. tx_pin high for 20 clk at the end.
- FIFO_DEPTH=16, valid held high with 20 incrementing words from idle:
  - Exactly 17 words are accepted (1 popped plus 16 stored), then tx_data_ready = 0 and fifo_level = 16.
  - Frames follow back-to-back with no idle high between stop and start.
  - Words transmit in order; ready reasserts after the next pop.
- Simultaneous push and pop at frame boundary with fifo_level = 3 -> fifo_level stays 3, with no drop and no duplicate.
- Assert rst_n low in the middle of a DATA bit with 5 words queued -> tx_pin = 1 immediately, fifo_level = 0, no tx_ack. After release, ready = 1 next edge and a new word transmits correctly.
